// File: rtl/inst_fetch_responder.sv
// Instruction-memory fetch responder: fixed wait-state latency, branch flush, program-load port.
// Optional macro STALL_COUNT_EN adds a saturating stall-cycle counter on stall_cnt.
module inst_fetch_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  input  logic        flush,
  input  logic        ld_we,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_inst,
  output logic [31:0] rsp_addr,
  output logic        rsp_err,
  output logic [31:0] stall_cnt
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_addr_q, rsp_addr_d;
  logic        rsp_err_q, rsp_err_d;
  logic        rsp_ok_q, rsp_ok_d;
  logic [31:0] rd_data_q;

  logic [31:0] mem [DEPTH];

  logic [31:0] fetch_addr;
  logic [29:0] fetch_idx;
  logic        fetch_err;
  logic        enter_resp;
  logic [29:0] ld_idx;
  logic        ld_in_range;
  logic        unused_ld_lsb;

  // With zero wait states the fetch enters RESP on the accepting edge, so it reads req_addr directly.
  assign fetch_addr  = (state_q == S_WAIT) ? addr_q : req_addr;
  assign fetch_idx   = fetch_addr[31:2];
  assign fetch_err   = (fetch_addr[1:0] != 2'b00) || ({2'b00, fetch_idx} >= 32'(DEPTH));
  assign enter_resp  = (state_d == S_RESP);
  assign ld_idx      = ld_addr[31:2];
  assign ld_in_range = ({2'b00, ld_idx} < 32'(DEPTH));
  assign unused_ld_lsb = ^ld_addr[1:0];

  assign stall = (state_q == S_WAIT) || (req_valid && (state_q != S_WAIT));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE, S_RESP: begin
        state_d = S_IDLE;
        if (req_valid) begin
          addr_d  = req_addr;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        if (flush) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase

    rsp_valid_d = enter_resp;
    rsp_addr_d  = enter_resp ? fetch_addr : rsp_addr_q;
    rsp_err_d   = enter_resp ? fetch_err : rsp_err_q;
    rsp_ok_d    = enter_resp ? !fetch_err : rsp_ok_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= 32'd0;
      rsp_err_q   <= 1'b0;
      rsp_ok_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_err_q   <= rsp_err_d;
      rsp_ok_q    <= rsp_ok_d;
    end
  end

  // Non-blocking write and read on the same edge give read-before-write for a colliding word.
  always_ff @(posedge clk) begin
    if (ld_we && ld_in_range) mem[ld_idx[AW-1:0]] <= ld_data;
    if (enter_resp && !fetch_err) rd_data_q <= mem[fetch_idx[AW-1:0]];
  end

  // rsp_ok_q masks the unreset RAM output after reset and forces the NOP on errors.
  assign rsp_valid = rsp_valid_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_inst  = rsp_ok_q ? rd_data_q : 32'h0000_0000;

`ifdef STALL_COUNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= 32'd0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: doc/inst_fetch_responder.md
Name: inst_fetch_responder

Overview:
- Instruction-memory responder on the far side of the fetch interface. Accepts word-aligned fetch requests from the IF stage and returns each instruction after a fixed, configurable number of wait states.
- Drives a stall line back to the pipeline freeze logic.
- Honours branch-flush of in-flight fetches.
- Provides a load port for program download.

Parameters:
- DEPTH, 256: memory size in 32-bit words; power of two.
- WAIT_CYCLES, 2: wait states per fetch; range 0..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  fetch request present this cycle
- req_addr  in  32  byte address of the fetch
- flush  in  1  branch taken; abort any in-flight fetch
- ld_we  in  1  program-load write enable
- ld_addr  in  32  program-load byte address
- ld_data  in  32  program-load word
- stall  out  1  fetch not yet complete; pipeline must freeze
- rsp_valid  out  1  one-cycle pulse; response fields valid
- rsp_inst  out  32  fetched instruction
- rsp_addr  out  32  byte address of the returned instruction
- rsp_err  out  1  misaligned or out-of-range fetch
- stall_cnt  out  32  stall-cycle counter (see Optional Feature)

Behaviour:
- Reset values:
  - state IDLE; wait counter 0.
  - rsp_valid 0, rsp_inst 0, rsp_addr 0, rsp_err 0, stall_cnt 0.
  - Memory contents are not reset.
- Word index: req_addr[31:2]. A request is out of range if index >= DEPTH. It is misaligned if req_addr[1:0] != 0.
- FSM states: IDLE, WAIT, RESP.
  - IDLE with req_valid=1: accept; latch address; counter loads WAIT_CYCLES. Go to WAIT if WAIT_CYCLES > 0, otherwise RESP.
  - WAIT: counter decrements each cycle. When the counter reaches 1 and decrements, go to RESP on the next edge.
  - RESP: rsp_valid=1 for exactly one cycle. If req_valid=1 in this cycle, accept back-to-back (same rules as IDLE); otherwise go to IDLE.
- Latency:
  - rsp_valid rises WAIT_CYCLES+1 clock edges after the accepting edge's cycle.
  - Steady back-to-back throughput is one instruction per WAIT_CYCLES+1 cycles.
- Memory read and rsp_inst/rsp_addr/rsp_err are registered on the edge entering RESP. The fields hold their values until the next response; they are not cleared when rsp_valid drops.
- Error response: rsp_err=1 and rsp_inst=32'h0000_0000 (NOP). Latency is unchanged; memory is not read.
- Stall: combinational. stall=1 when (state==WAIT) or (req_valid=1 and state is IDLE or RESP). stall=0 otherwise, including the RESP cycle when req_valid=0.
- Flush:
  - In WAIT: return to IDLE on the next edge; no rsp_valid for the aborted fetch.
  - In RESP: the response pulse still occurs; the consumer discards it.
  - flush together with req_valid in IDLE/RESP: the new request is accepted; flush affects only fetches already in flight.
- Load port:
  - ld_we writes mem[ld_addr[31:2]] on the clock edge. Writes are ignored when out of range; ld_addr[1:0] is ignored.
  - A write and a fetch read of the same word on the same edge return the OLD data (read-before-write).
- Reset asserted mid-fetch: immediately IDLE, all outputs return to reset values, and the pending fetch is lost.

Optional Feature:
- Macro STALL_COUNT_EN.
  - Defined: stall_cnt increments by 1 on every clock edge where stall=1. It saturates at 32'hFFFF_FFFF and clears only on rst.
  - Undefined: stall_cnt is tied to 0 and the counter register is not synthesised.

Test Plan:
- WAIT_CYCLES=2; load mem[1]=32'hE3A0_1005; req_addr=4 held one cycle in IDLE -> stall high 3 cycles. rsp_valid pulses 3 cycles after acceptance with rsp_inst=32'hE3A0_1005, rsp_addr=4, rsp_err=0.
- Back-to-back req_valid held, addr 0,4,8 presented at each accept -> rsp_valid every 3 cycles, in order, with rsp_addr 0,4,8.
- Request addr 8, then flush asserted in the first WAIT cycle -> no rsp_valid. A request for addr 12 issued at the same time as flush from IDLE returns normally.
- req_addr=6 (misaligned) and req_addr=DEPTH*4 (out of range) -> rsp_err=1, rsp_inst=0, same latency.
- WAIT_CYCLES=0 -> rsp_valid one cycle after acceptance. A continuous request stream gives one response per cycle with stall=1 on request cycles. Asserting rst mid-WAIT with WAIT_CYCLES=4 -> outputs return to reset values and no response follows.
- With STALL_COUNT_EN defined, run scenario 1 -> stall_cnt=3. Undefined -> stall_cnt stays 0.
